// File: rtl/ed060sc7_panel_rx.sv
// Panel-side decoder for the ED060SC7 source/gate timing stream.
// Rebuilds the source shift and line latch, and emits framebuffer byte writes, line/frame events and error flags.
module ed060sc7_panel_rx #(
   parameter int SOURCE_BYTES = 200,
   parameter int GATE_LINES   = 600,
   parameter int ADDR_W       = 17
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              cl,
   input  logic              sph,
   input  logic              le,
   input  logic              spv,
   input  logic              ckv,
   input  logic              oe,
   input  logic [7:0]        data,
   input  logic              clear_err,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              line_done,
   output logic [9:0]        line_row,
   output logic              frame_done,
   output logic [7:0]        frame_cnt,
   output logic              err_short,
   output logic              err_long,
   output logic              err_frame
);

   localparam int COL_W = $clog2(SOURCE_BYTES + 1);

   typedef enum logic [1:0] {IDLE, WAIT_SPH, SHIFT, WAIT_LE} state_t;

   state_t            state;
   logic [COL_W-1:0]  col;
   logic [9:0]        row;
   logic [ADDR_W-1:0] base;
   logic              cl_p0, spv_p0, le_p0;
   logic              cl_rise, spv_fall, le_rise;
   logic              le_evt, frame_end, capture, long_evt;
   logic              unused_ckv;

   // ckv only matters to whoever monitors the gate side; writes never depend on it.
   assign unused_ckv = ckv;

   // Edge detect: raw sample against one history register per input.
   assign cl_rise  = cl & ~cl_p0;
   assign spv_fall = ~spv & spv_p0;
   assign le_rise  = le & ~le_p0;

   assign le_evt    = le_rise & ((state == SHIFT) | (state == WAIT_LE));
   assign frame_end = le_evt & (row == 10'(GATE_LINES - 1));
   assign capture   = cl_rise & oe & ~le_evt & ~spv_fall &
                      (((state == WAIT_SPH) & ~sph) | (state == SHIFT));
   assign long_evt  = cl_rise & ~sph & ~le_evt & (state == WAIT_LE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         base       <= '0;
         cl_p0      <= 1'b0;
         spv_p0     <= 1'b1;
         le_p0      <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         line_done  <= 1'b0;
         line_row   <= '0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
         err_short  <= 1'b0;
         err_long   <= 1'b0;
         err_frame  <= 1'b0;
      end else begin
         cl_p0      <= cl;
         spv_p0     <= spv;
         le_p0      <= le;
         wr_en      <= 1'b0;
         line_done  <= 1'b0;
         frame_done <= 1'b0;
         // A new error later in this block wins over a simultaneous clear.
         err_short  <= err_short & ~clear_err;
         err_long   <= err_long & ~clear_err;
         err_frame  <= err_frame & ~clear_err;

         if (!enable) begin
            state <= IDLE;
            col   <= '0;
         end else if (state == IDLE) begin
            if (spv_fall) begin
               state <= WAIT_SPH;
               row   <= '0;
               base  <= '0;
               col   <= '0;
            end
         end else begin
            if (le_evt) begin
               if (state == SHIFT) err_short <= 1'b1;
               line_done <= 1'b1;
               line_row  <= row;
               col       <= '0;
               if (frame_end) begin
                  frame_done <= 1'b1;
                  frame_cnt  <= frame_cnt + 8'd1;
                  row        <= '0;
                  base       <= '0;
                  state      <= IDLE;
               end else begin
                  row   <= row + 10'd1;
                  base  <= base + ADDR_W'(SOURCE_BYTES);
                  state <= WAIT_SPH;
               end
            end

            if (capture) begin
               wr_en   <= 1'b1;
               wr_data <= data;
               wr_addr <= base + ADDR_W'(col);
               col     <= col + COL_W'(1);
               state   <= (col == COL_W'(SOURCE_BYTES - 1)) ? WAIT_LE : SHIFT;
            end

            if (long_evt) err_long <= 1'b1;

            // Restart after any same-clk latch has been reported.
            if (spv_fall) begin
               if (!frame_end) begin
                  row  <= '0;
                  base <= '0;
                  if (le_evt || (row != 10'd0)) err_frame <= 1'b1;
               end
               state <= WAIT_SPH;
               col   <= '0;
            end
         end
      end
   end

endmodule
